lane_obstacle_engine: RTL and testbench

Parametrised multi-lane obstacle animator for the frogger VGA display. Holds one horizontally moving obstacle per lane. Each lane has its own enable, direction and speed, and lanes wrap at the screen edge. Each cycle it returns the pixel colour for the vga_driver's next_x/next_y and a registered frog-collision flag. It sits between the game FSM and vga_driver and replaces hand-coded per-position enemy states.

---
 rtl/lane_obstacle_engine.sv | 160 ++++++++++++++++
 tb/tb_lane_obstacle_engine.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_obstacle_engine.sv
// lane_obstacle_engine: multi-lane obstacle animator for the frogger VGA display.
// Each lane holds one horizontally moving obstacle that wraps at the screen edge.
// Produces a registered pixel colour for the vga_driver's next_x/next_y and a
// registered frog-collision flag.
// Optional build macro OBSTACLE_PAIR_EN adds a second obstacle per lane, placed
// half a screen away from the first.
module lane_obstacle_engine #(
  parameter int NUM_LANES = 4,
  parameter int SCREEN_W  = 640,
  parameter int LANE_Y0   = 48,
  parameter int LANE_H    = 48,
  parameter int OBJ_W     = 32,
  parameter int FROG_W    = 32,
  parameter int STEP_PX   = 32,
  parameter int TICK_DIV  = 50000000,
  parameter logic [7:0] OBJ_COLOR  = 8'b00011100,
  parameter logic [7:0] LANE_COLOR = 8'b01001001,
  parameter logic [7:0] BG_COLOR   = 8'b00000000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pause,
  input  logic [NUM_LANES-1:0]   lane_en,
  input  logic [NUM_LANES-1:0]   lane_dir,
  input  logic [4*NUM_LANES-1:0] lane_period,
  input  logic [9:0]             next_x,
  input  logic [9:0]             next_y,
  input  logic [9:0]             frog_x,
  input  logic [2:0]             frog_lane,
  input  logic                   frog_valid,
  output logic [7:0]             color_out,
  output logic                   collide,
  output logic [NUM_LANES-1:0]   step_pulse
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [10:0] SW = 11'(SCREEN_W);
  localparam logic [10:0] ST = 11'(STEP_PX);
  localparam logic [10:0] OW = 11'(OBJ_W);
  localparam logic [10:0] FW = 11'(FROG_W);

  // True when a lies in the circular interval [start, start+width) modulo SCREEN_W.
  function automatic logic in_span(input logic [10:0] a, input logic [10:0] start,
                                   input logic [10:0] width);
    logic [10:0] d;
    d = (a >= start) ? (a - start) : (a + SW - start);
    return d < width;
  endfunction

  logic [TW-1:0]        tick_cnt;
  logic                 base_tick;
  logic [NUM_LANES-1:0] en_q;
  logic [NUM_LANES-1:0] in_band;
  logic [NUM_LANES-1:0] obj_hit;
  logic [NUM_LANES-1:0] frog_hit;
  logic [NUM_LANES-1:0] lane_step;
  logic [10:0]          x_w;
  logic [10:0]          fx_w;
  logic [7:0]           color_next;

  assign x_w  = {1'b0, next_x};
  assign fx_w = {1'b0, frog_x};

  // Pause both freezes the divider and masks the tick it would have produced.
  assign base_tick = !pause && (tick_cnt == TICK_LAST);

  // Base tick divider: counts 0..TICK_DIV-1, holds while paused.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (!pause) begin
      tick_cnt <= base_tick ? '0 : tick_cnt + TW'(1);
    end
  end

  // Previous-cycle enables so a lane switched on during a tick cycle skips that tick.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) en_q <= '0;
    else        en_q <= lane_en;
  end

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic [9:0]  pos;
    logic [3:0]  step_cnt;
    logic [3:0]  period;
    logic [10:0] pos_w;
    logic [10:0] pos_fwd;
    logic [10:0] pos_next;
    logic        lane_tick;
    logic        x_hit;
    logic        f_hit;

    assign period    = lane_period[4*gi +: 4];
    assign pos_w     = {1'b0, pos};
    assign pos_fwd   = pos_w + ST;
    assign pos_next  = lane_dir[gi] ? ((pos_w < ST) ? (pos_w + SW - ST) : (pos_w - ST))
                                    : ((pos_fwd >= SW) ? (pos_fwd - SW) : pos_fwd);
    assign lane_tick = base_tick && lane_en[gi] && en_q[gi];
    assign lane_step[gi] = lane_tick && (step_cnt >= period);

    // Per-lane step counter and position; moves once every (period+1) base ticks.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        pos      <= '0;
        step_cnt <= '0;
      end else if (lane_tick) begin
        if (step_cnt >= period) begin
          step_cnt <= '0;
          pos      <= pos_next[9:0];
        end else begin
          step_cnt <= step_cnt + 4'd1;
        end
      end
    end

`ifdef OBSTACLE_PAIR_EN
    localparam logic [10:0] HALF = 11'(SCREEN_W / 2);
    logic [10:0] pos_b_sum;
    logic [10:0] pos_b;
    assign pos_b_sum = pos_w + HALF;
    assign pos_b     = (pos_b_sum >= SW) ? (pos_b_sum - SW) : pos_b_sum;
    assign x_hit = in_span(x_w, pos_w, OW) || in_span(x_w, pos_b, OW);
    assign f_hit = in_span(pos_w, fx_w, FW) || in_span(fx_w, pos_w, OW) ||
                   in_span(pos_b, fx_w, FW) || in_span(fx_w, pos_b, OW);
`else
    assign x_hit = in_span(x_w, pos_w, OW);
    // Two circular intervals overlap iff either start lies inside the other.
    assign f_hit = in_span(pos_w, fx_w, FW) || in_span(fx_w, pos_w, OW);
`endif

    assign in_band[gi]  = ({1'b0, next_y} >= 11'(LANE_Y0 + gi * LANE_H)) &&
                          ({1'b0, next_y} <  11'(LANE_Y0 + (gi + 1) * LANE_H));
    assign obj_hit[gi]  = in_band[gi] && lane_en[gi] && x_hit;
    assign frog_hit[gi] = (frog_lane == 3'(gi)) && lane_en[gi] && f_hit;
  end

  // Pixel colour priority: obstacle over lane background over screen background.
  always_comb begin
    color_next = BG_COLOR;
    if (x_w < SW) begin
      if (|obj_hit)      color_next = OBJ_COLOR;
      else if (|in_band) color_next = LANE_COLOR;
    end
  end

  // Output registers: one-cycle latency for colour, collision and step pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      color_out  <= BG_COLOR;
      collide    <= 1'b0;
      step_pulse <= '0;
    end else begin
      color_out  <= color_next;
      collide    <= frog_valid && (|frog_hit);
      step_pulse <= lane_step;
    end
  end

endmodule

// File: tb/tb_lane_obstacle_engine.sv
// Scoreboard bench for lane_obstacle_engine: a cycle model built from modular
// arithmetic pushes expected outputs; a monitor pops and compares each cycle.
module tb_lane_obstacle_engine;
  localparam int NL = 4, SW = 640, Y0 = 48, LH = 48, OW = 32, FW = 32, ST = 32, TD = 4;
  localparam logic [7:0] OBJ_C = 8'b00011100, LANE_C = 8'b01001001, BG_C = 8'b00000000;

  logic          clock = 0, reset = 1, pause = 0, frog_valid = 0;
  logic [NL-1:0] lane_en = '0, lane_dir = '0;
  logic [4*NL-1:0] lane_period = '0;
  logic [9:0]    next_x = '0, next_y = '0, frog_x = '0;
  logic [2:0]    frog_lane = '0;
  logic [7:0]    color_out;
  logic          collide;
  logic [NL-1:0] step_pulse;

  lane_obstacle_engine #(.NUM_LANES(NL), .TICK_DIV(TD)) dut (
    .clock(clock), .reset(reset), .pause(pause), .lane_en(lane_en), .lane_dir(lane_dir),
    .lane_period(lane_period), .next_x(next_x), .next_y(next_y), .frog_x(frog_x),
    .frog_lane(frog_lane), .frog_valid(frog_valid), .color_out(color_out),
    .collide(collide), .step_pulse(step_pulse));

  always #5 clock = ~clock;

  typedef struct { logic [7:0] color; logic coll; logic [NL-1:0] pulse; } exp_t;
  exp_t exp_q[$];
  int checks = 0, passed = 0;

  // Reference model state
  int m_tick;
  int m_cnt[NL];
  int m_pos[NL];
  logic [NL-1:0] m_en_prev;

  // Staged stimulus, applied just after a rising edge
  logic [NL-1:0] c_en = '0, c_dir = '0;
  logic [4*NL-1:0] c_period = '0;
  logic c_pause = 0, fix_xy = 0, fix_frog = 0, c_fvalid = 0;
  int c_x = 0, c_y = 0, c_fx = 0, c_fl = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit covers(int p, int x);
    bit hit;
    hit = ((x - p + SW) % SW) < OW;
`ifdef OBSTACLE_PAIR_EN
    hit = hit || (((x - ((p + SW / 2) % SW) + SW) % SW) < OW);
`endif
    return hit;
  endfunction

  function automatic logic [7:0] model_color(int x, int y);
    int l;
    if (x >= SW) return BG_C;
    if (y < Y0 || y >= Y0 + NL * LH) return BG_C;
    l = (y - Y0) / LH;
    if (lane_en[l] && covers(m_pos[l], x)) return OBJ_C;
    return LANE_C;
  endfunction

  function automatic logic model_collide();
    int l;
    l = int'(frog_lane);
    if (!frog_valid || l >= NL) return 1'b0;
    if (!lane_en[l]) return 1'b0;
    for (int k = 0; k < FW; k++)
      if (covers(m_pos[l], (int'(frog_x) + k) % SW)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_tick = 0;
    m_en_prev = '0;
    for (int i = 0; i < NL; i++) begin m_cnt[i] = 0; m_pos[i] = 0; end
  endtask

  // One clock of the model: outputs from the current state, then advance it.
  task automatic model_step();
    exp_t e;
    bit base;
    int per;
    e.color = model_color(int'(next_x), int'(next_y));
    e.coll  = model_collide();
    e.pulse = '0;
    base = !pause && (m_tick == TD - 1);
    for (int i = 0; i < NL; i++) begin
      per = int'(lane_period[4*i +: 4]);
      if (base && lane_en[i] && m_en_prev[i]) begin
        if (m_cnt[i] >= per) begin
          m_cnt[i] = 0;
          m_pos[i] = lane_dir[i] ? (m_pos[i] - ST + SW) % SW : (m_pos[i] + ST) % SW;
          e.pulse[i] = 1'b1;
        end else begin
          m_cnt[i]++;
        end
      end
    end
    m_en_prev = lane_en;
    if (!pause) m_tick = base ? 0 : m_tick + 1;
    exp_q.push_back(e);
  endtask

  task automatic pick_stim();
    int r, l;
    r = $urandom_range(0, 3);
    l = $urandom_range(0, NL - 1);
    if (r == 0) begin
      next_x = 10'($urandom_range(0, 700));
      next_y = 10'($urandom_range(0, 300));
    end else if (r == 3) begin
      case ($urandom_range(0, 3))
        0: next_x = 10'd0;
        1: next_x = 10'(SW - 1);
        2: next_x = 10'(SW);
        default: next_x = 10'd1023;
      endcase
      next_y = 10'(Y0 + l * LH + $urandom_range(0, LH - 1));
    end else begin
      next_x = 10'((m_pos[l] + $urandom_range(0, OW + 16) + SW - 8) % SW);
      next_y = 10'(Y0 + l * LH + $urandom_range(0, LH - 1));
    end
    frog_valid = ($urandom_range(0, 7) != 0);
    frog_lane  = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, NL - 1)) : 3'($urandom_range(0, 7));
    if (int'(frog_lane) < NL && $urandom_range(0, 1) == 1) begin
      r = m_pos[int'(frog_lane)] + $urandom_range(0, 80) - 40;
      if (r < 0) r = 0;
      if (r > SW - FW) r = SW - FW;
      frog_x = 10'(r);
    end else begin
      frog_x = 10'($urandom_range(0, SW - FW));
    end
  endtask

  task automatic do_cycle();
    @(posedge clock);
    #1;
    reset = 1'b1;
    lane_en = c_en; lane_dir = c_dir; lane_period = c_period; pause = c_pause;
    pick_stim();
    if (fix_xy) begin next_x = 10'(c_x); next_y = 10'(c_y); end
    if (fix_frog) begin frog_x = 10'(c_fx); frog_lane = 3'(c_fl); frog_valid = c_fvalid; end
    @(negedge clock);
    model_step();
  endtask

  // Asynchronous reset between edges; outputs must clear at once.
  task automatic mid_reset();
    @(posedge clock);
    #4;
    reset = 1'b0;
    #1;
    chk("async_rst_color", 32'(color_out), 32'(BG_C));
    chk("async_rst_collide", 32'(collide), 32'd0);
    chk("async_rst_pulse", 32'(step_pulse), 32'd0);
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge clock);
  endtask

  // Monitor: compare every registered output against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("color_out", 32'(color_out), 32'(e.color));
        chk("collide", 32'(collide), 32'(e.coll));
        chk("step_pulse", 32'(step_pulse), 32'(e.pulse));
      end
    end
  end

  initial begin
    #2 reset = 1'b0;
    #1;
    chk("reset_color", 32'(color_out), 32'(BG_C));
    chk("reset_collide", 32'(collide), 32'd0);
    chk("reset_pulse", 32'(step_pulse), 32'd0);
    model_reset();
    repeat (2) @(posedge clock);

    // Lane 0 forward, one step per base tick
    c_en = 4'b0001; c_dir = '0; c_period = '0;
    repeat (40) do_cycle();
    fix_xy = 1; c_x = SW - 1; c_y = Y0 + 5;
    do_cycle();
    fix_xy = 0;
    mid_reset();

    // Leftward from 0 wraps to SW-STEP; probe both screen edges
    c_dir = 4'b0001;
    repeat (4) do_cycle();
    fix_xy = 1; c_y = Y0 + 10;
    c_x = 620; do_cycle();
    c_x = 5;   do_cycle();
    c_x = 600; do_cycle();
    c_dir = 4'b0000;
    c_x = 300; do_cycle();
    c_x = 5;   do_cycle();
    c_x = 620; do_cycle();
    fix_xy = 0;

    // Slower lane: period 2
    c_period = 16'h0002;
    repeat (40) do_cycle();

    // Pause mid-count
    repeat (2) do_cycle();
    c_pause = 1;
    repeat (10) do_cycle();
    c_pause = 0;
    repeat (20) do_cycle();

    // Frog collision at pos0=32, then the lane disabled
    mid_reset();
    c_en = 4'b0001; c_dir = '0; c_period = '0;
    repeat (4) do_cycle();
    fix_frog = 1; c_fx = 40; c_fl = 0; c_fvalid = 1;
    fix_xy = 1; c_x = 40; c_y = Y0 + 3;
    do_cycle();
    c_en = 4'b0000;
    do_cycle();
    c_x = 100; do_cycle();
    fix_frog = 0; fix_xy = 0;

    // Randomised traffic across all lanes
    for (int n = 0; n < 2400; n++) begin
      if (n % 64 == 0) begin
        c_en  = NL'($urandom);
        c_dir = NL'($urandom);
        for (int i = 0; i < NL; i++) c_period[4*i +: 4] = 4'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 30) == 0) c_pause = ~c_pause;
      if (n == 1200) mid_reset();
      do_cycle();
    end

    @(posedge clock);
    #5;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
